// File: rtl/imem_boot_loader.sv
// Boot loader: packs a byte stream little-endian into 32-bit words, writes them to imem,
// and holds the processor reset until the image is complete plus a settle window.
module imem_boot_loader #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] wr_address,
  output logic [31:0]       wr_data,
  output logic              wr_en,
  output logic [ADDR_W:0]   word_count,
  output logic              proc_reset,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        lane, lane_nx;
  logic [31:0]       asm_buf, asm_nx;
  logic [ADDR_W:0]   count_nx;
  logic [1:0]        error_nx;
  logic [CNT_W-1:0]  hold_cnt, hold_nx;
  logic              wr_en_nx;
  logic [31:0]       wr_data_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [31:0]       merged;
  logic              accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      lane       <= 2'd0;
      asm_buf    <= 32'd0;
      word_count <= '0;
      error      <= 2'b00;
      hold_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_data    <= 32'd0;
      wr_address <= '0;
    end else begin
      state      <= state_nx;
      lane       <= lane_nx;
      asm_buf    <= asm_nx;
      word_count <= count_nx;
      error      <= error_nx;
      hold_cnt   <= hold_nx;
      wr_en      <= wr_en_nx;
      wr_data    <= wr_data_nx;
      wr_address <= wr_addr_nx;
    end
  end

  // Lanes above the current one are always zero in asm_buf, so OR-ing in the
  // new byte yields the zero-filled word needed for a short final word.
  assign merged = asm_buf | ({24'd0, byte_data} << {lane, 3'b000});
  assign accept = byte_valid && (state == S_LOAD);

  always_comb begin
    state_nx   = state;
    lane_nx    = lane;
    asm_nx     = asm_buf;
    count_nx   = word_count;
    error_nx   = error;
    hold_nx    = hold_cnt;
    wr_en_nx   = 1'b0;
    wr_data_nx = wr_data;
    wr_addr_nx = wr_address;

    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_nx = S_LOAD;
          lane_nx  = 2'd0;
          asm_nx   = 32'd0;
          count_nx = '0;
          error_nx = 2'b00;
        end
      end

      S_LOAD: begin
        if (accept) begin
          if (word_count == DEPTH_C) begin
            // Overflow takes priority over byte_last: nothing is written.
            error_nx[1] = 1'b1;
            state_nx    = S_ERR;
          end else if ((lane == 2'd3) || byte_last) begin
            wr_en_nx   = 1'b1;
            wr_data_nx = merged;
            wr_addr_nx = word_count[ADDR_W-1:0];
            count_nx   = word_count + (ADDR_W + 1)'(1);
            asm_nx     = 32'd0;
            lane_nx    = 2'd0;
            if (byte_last) begin
              if (lane != 2'd3) error_nx[0] = 1'b1;
              state_nx = S_HOLD;
              hold_nx  = HOLD_C;
            end
          end else begin
            asm_nx  = merged;
            lane_nx = lane + 2'd1;
          end
        end
      end

      S_HOLD: begin
        if (hold_cnt == '0) state_nx = S_RUN;
        else                hold_nx  = hold_cnt - CNT_W'(1);
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign byte_ready = (state == S_LOAD);
  assign busy       = (state == S_LOAD) || (state == S_HOLD);
  assign done       = (state == S_RUN);
  assign proc_reset = (state != S_RUN);

endmodule
